// File: rtl/mux_2x1_nbits.sv
// Registered 2-to-1 multiplexer of parameterizable width.
// Loads the selected input into xout on an enabled rising edge. Pulses out_valid for one
// cycle after each enabled load, and sel_err when the load saw a sel that was not 0 or 1.
// Optional feature macro: MUX_BYPASS_EN adds the combinational output xout_comb.
module mux_2x1_nbits #(
  parameter int unsigned bits        = 4,
  parameter logic [63:0] DEFAULT_VAL = 64'd0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            sel,
  input  logic [bits-1:0] xin_0,
  input  logic [bits-1:0] xin_1,
  output logic [bits-1:0] xout,
  output logic            out_valid,
  output logic            sel_err
`ifdef MUX_BYPASS_EN
  ,
  output logic [bits-1:0] xout_comb
`endif
);

  // DEFAULT_VAL is truncated or zero-extended to the datapath width.
  localparam logic [bits-1:0] DefaultW = DEFAULT_VAL[bits-1:0];

  logic [bits-1:0] mux_val;
  logic            mux_bad;
  logic [bits-1:0] xout_q, xout_d;
  logic            out_valid_q, out_valid_d;
  logic            sel_err_q, sel_err_d;

  // Selection with case-equality matching; X/Z on sel falls through to the default value.
  always_comb begin
    mux_val = DefaultW;
    mux_bad = 1'b0;
    case (sel)
      1'b0:    mux_val = xin_0;
      1'b1:    mux_val = xin_1;
      default: begin
        mux_val = DefaultW;
        mux_bad = 1'b1;
      end
    endcase
  end

  // Next-state: load on enable, hold data otherwise; status flags are one-cycle pulses.
  always_comb begin
    xout_d      = xout_q;
    out_valid_d = 1'b0;
    sel_err_d   = 1'b0;
    if (en) begin
      xout_d      = mux_val;
      out_valid_d = 1'b1;
      sel_err_d   = mux_bad;
    end
  end

  // State registers with synchronous active-high reset that overrides en.
  always_ff @(posedge clk) begin
    if (rst) begin
      xout_q      <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      xout_q      <= xout_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign xout      = xout_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

`ifdef MUX_BYPASS_EN
  // Unregistered view of the same selection, independent of clk, rst and en.
  assign xout_comb = mux_val;
`endif

endmodule

// File: tb/tb_mux_2x1_nbits.sv
// Directed self-checking bench for mux_2x1_nbits (bits = 4, DEFAULT_VAL = 0).
module tb_mux_2x1_nbits;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sel;
  logic [3:0] xin_0;
  logic [3:0] xin_1;
  logic [3:0] xout;
  logic       out_valid;
  logic       sel_err;
`ifdef MUX_BYPASS_EN
  logic [3:0] xout_comb;
`endif

  int n_checks;
  int n_errors;

  mux_2x1_nbits #(
    .bits       (4),
    .DEFAULT_VAL(64'd0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sel      (sel),
    .xin_0    (xin_0),
    .xin_1    (xin_1),
    .xout     (xout),
    .out_valid(out_valid),
    .sel_err  (sel_err)
`ifdef MUX_BYPASS_EN
    ,
    .xout_comb(xout_comb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] exp_x, input logic exp_v,
                           input logic exp_e);
    check({tag, ".xout"}, 64'(xout), 64'(exp_x));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_v));
    check({tag, ".sel_err"}, 64'(sel_err), 64'(exp_e));
  endtask

  initial begin
    logic xprobe;
    n_checks = 0;
    n_errors = 0;

    // Reset for two cycles with arbitrary inputs and en high.
    rst   = 1'b1;
    en    = 1'b1;
    sel   = 1'b1;
    xin_0 = 4'b1111;
    xin_1 = 4'b0011;
    tick();
    tick();
    check_out("reset", 4'b0000, 1'b0, 1'b0);

    // Back-to-back loads, one result per cycle.
    rst   = 1'b0;
    xin_0 = 4'b1010;
    xin_1 = 4'b1100;
    sel   = 1'b0;
    tick();
    check_out("sel0", 4'b1010, 1'b1, 1'b0);
    sel = 1'b1;
    tick();
    check_out("sel1", 4'b1100, 1'b1, 1'b0);
    xin_0 = 4'b0001;
    xin_1 = 4'b1110;
    sel   = 1'b0;
    tick();
    check_out("sel0_b", 4'b0001, 1'b1, 1'b0);

    // Invalid sel only exists on a four-state simulator.
    xprobe = 1'bx;
    if (xprobe === 1'bx) begin
      sel = 1'bx;
      tick();
      check_out("selx", 4'b0000, 1'b1, 1'b1);
    end
    xin_0 = 4'b0110;
    sel   = 1'b0;
    tick();
    check_out("after_selx", 4'b0110, 1'b1, 1'b0);

    xin_0 = 4'b0101;
    xin_1 = 4'b1001;
    sel   = 1'b1;
    tick();
    check_out("sel1_b", 4'b1001, 1'b1, 1'b0);

    // Hold with en low while inputs toggle.
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      xin_0 = 4'(i * 3 + 2);
      xin_1 = 4'(15 - i);
      sel   = ~sel;
      tick();
      check_out($sformatf("hold%0d", i), 4'b1001, 1'b0, 1'b0);
    end

    // A reset pulse between edges must be ignored.
    en    = 1'b1;
    sel   = 1'b0;
    xin_0 = 4'b0011;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    check_out("rst_between_edges", 4'b0011, 1'b1, 1'b0);

    // Reset overrides en.
    rst   = 1'b1;
    en    = 1'b1;
    sel   = 1'b1;
    xin_1 = 4'b0111;
    tick();
    check_out("rst_over_en", 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;

`ifdef MUX_BYPASS_EN
    // Combinational path follows sel mid-cycle; registered output waits for the edge.
    en    = 1'b0;
    xin_0 = 4'b0011;
    xin_1 = 4'b1100;
    sel   = 1'b0;
    #1;
    check("comb_sel0", 64'(xout_comb), 64'(4'b0011));
    sel = 1'b1;
    #1;
    check("comb_sel1", 64'(xout_comb), 64'(4'b1100));
    check("comb_xout_unchanged", 64'(xout), 64'(4'b0000));
    en = 1'b1;
    tick();
    check("comb_xout_after_edge", 64'(xout), 64'(4'b1100));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_2x1_nbits.md
Name: mux_2x1_nbits

Overview:
- Registered 2-to-1 multiplexer of parameterizable width.
- Selects `xin_0` or `xin_1` based on `sel` and registers the result on the rising clock edge.
- Drives a defined default value when `sel` is unknown (X/Z).
- Generic datapath building block in the video display processor library; used wherever a clocked operand or address choice is needed.

Parameters:
- `bits`, 4: data width of `xin_0`, `xin_1` and `xout`; legal range 1..64.
- `DEFAULT_VAL`, 0: value loaded into `xout` when `sel` is not a clean 0 or 1; truncated/zero-extended to `bits`.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `en`  input  1  load enable; when low, `xout` holds.
- `sel`  input  1  select: 0 picks `xin_0`, 1 picks `xin_1`.
- `xin_0`  input  bits  data input 0.
- `xin_1`  input  bits  data input 1.
- `xout`  output  bits  registered selected data.
- `out_valid`  output  1  high for one cycle after each enabled load.
- `sel_err`  output  1  high for one cycle after an enabled load with invalid `sel`.

Behaviour:
- Single clock domain. All outputs are registered; no combinational input-to-output path, except the optional port below.
- Reset: at a rising `clk` with `rst`=1, `xout`=0, `out_valid`=0 and `sel_err`=0. Reset overrides `en`.
- Reset is synchronous only: asserting `rst` between edges has no effect until the next edge.
- Load: at a rising edge with `rst`=0 and `en`=1:
  - `sel`=0: `xout` <= `xin_0`.
  - `sel`=1: `xout` <= `xin_1`.
  - Any other `sel` (X/Z): `xout` <= `DEFAULT_VAL` and `sel_err` <= 1.
  - `out_valid` <= 1.
  - `sel_err` <= 0 on a valid `sel`.
- Hold: at a rising edge with `rst`=0 and `en`=0, `xout` keeps its value; `out_valid` <= 0 and `sel_err` <= 0.
- Latency: exactly 1 clock from an input sample to `xout`. Back-to-back loads are allowed every cycle (throughput 1 per clock).
- Input changes between edges are ignored; only the values at the rising edge matter.
- Width rule: no sign or width conversion. `xout` is a bit-exact copy of the selected input.
- Invalid `sel` detection uses case-equality semantics in simulation. In synthesis only the 0/1 branches exist; the default branch is unreachable but still coded.
- `out_valid` and `sel_err` are single-cycle pulses, never sticky.

Optional Feature:
- Macro: `MUX_BYPASS_EN`.
- Defined: adds output port `xout_comb` (width `bits`), a purely combinational version of the same selection. It follows `sel`/`xin_0`/`xin_1` immediately, is independent of `clk`, `rst` and `en`, and gives `DEFAULT_VAL` for invalid `sel`.
- Not defined: port `xout_comb` and its logic are absent. Registered behaviour is identical in both builds.

Test Plan:
- Reset: `rst`=1 for 2 cycles with arbitrary inputs -> `xout`=0000, `out_valid`=0, `sel_err`=0.
- Select 0: `en`=1, `xin_0`=1010, `xin_1`=1100, `sel`=0 -> next edge `xout`=1010, `out_valid`=1.
- Select 1: same data, `sel`=1 -> next edge `xout`=1100. Then `xin_0`=0001, `xin_1`=1110, `sel`=0 -> `xout`=0001. Then `xin_0`=0101, `xin_1`=1001, `sel`=1 -> `xout`=1001. All back-to-back, one result per cycle.
- Invalid `sel`: `sel`=X, `en`=1 -> next edge `xout`=`DEFAULT_VAL` (0000), `sel_err`=1 for one cycle. A following cycle with `sel`=0 -> `sel_err`=0.
- Hold: `xout`=1001, then `en`=0 while inputs toggle for 3 cycles -> `xout` stays 1001, `out_valid`=0. Then `rst`=1 with `en`=1 -> `xout`=0000 next edge.
- Bypass (`MUX_BYPASS_EN` defined): `sel` switches 0->1 mid-cycle with `xin_1`=1100 -> `xout_comb`=1100 immediately, while `xout` changes only at the next edge.
